cpu_iu: RTL and testbench

Instruction/control unit sitting directly upstream of the execution unit (EU). It holds the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake. It decodes the opcode into the EU control set (RegDst, ALUSrc, ALUOp, RegWrite, MemtoReg) plus data-RAM strobes, and computes the next PC using the EU's Zero flag and SEImm. It is a multi-cycle sequencer: FETCH, EXEC, MEM, WB.

---
 rtl/cpu_iu_pkg.sv | 36 +++
 rtl/cpu_iu_decode.sv | 46 ++++
 rtl/cpu_iu.sv | 144 ++++++++++++++
 tb/tb_cpu_iu.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_iu_pkg.sv
// Shared definitions for the cpu_iu instruction/control unit: opcodes,
// ALUOp encodings, sequencer states and the decoded control vector.
package cpu_iu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       is_beq;
        logic       is_j;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/cpu_iu_decode.sv
// Combinational opcode to control-vector decoder for cpu_iu.
// Undecoded opcodes yield an all-zero vector.
module cpu_iu_decode
    import cpu_iu_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl.is_beq = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
            end
            OP_J: begin
                ctrl.is_j = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/cpu_iu.sv
// Multi-cycle instruction/control unit (FETCH, EXEC, MEM, WB, HALT).
// Define ILLEGAL_TRAP_EN to halt on undecoded opcodes instead of treating them as NOPs.
module cpu_iu
    import cpu_iu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [25:0] Instruction,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic [1:0]  ALUOp,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic        mem_ack,
    input  logic        Zero,
    input  logic [31:0] SEImm,
    output logic [31:0] pc,
    output logic        halt
);

    localparam logic [31:0] TO_LAST = 32'(IMEM_TIMEOUT - 1);

    state_t      state, state_nx;
    logic [31:0] ir, ir_nx;
    logic [31:0] pc_nx;
    logic [31:0] to_cnt, to_cnt_nx;
    logic [31:0] pc_plus4, br_target, j_target;
    ctrl_t       ctrl;

    cpu_iu_decode u_decode (
        .opcode (ir[31:26]),
        .ctrl   (ctrl)
    );

    assign imem_addr   = pc;
    assign Instruction = ir[25:0];
    assign pc_plus4    = pc + 32'd4;
    assign br_target   = pc_plus4 + (SEImm << 2);
    assign j_target    = {pc_plus4[31:28], ir[25:0], 2'b00};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            to_cnt <= '0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            ir     <= ir_nx;
            to_cnt <= to_cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        ir_nx     = ir;
        to_cnt_nx = to_cnt;
        imem_req  = 1'b0;
        RegDst    = 1'b0;
        ALUSrc    = 1'b0;
        RegWrite  = 1'b0;
        MemtoReg  = 1'b0;
        ALUOp     = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        halt      = 1'b0;

        // EU controls stay stable from EXEC through WB for the held IR
        if (state == EXEC || state == MEM || state == WB) begin
            RegDst   = ctrl.reg_dst;
            ALUSrc   = ctrl.alu_src;
            MemtoReg = ctrl.mem_to_reg;
            ALUOp    = ctrl.alu_op;
        end

        case (state)
            FETCH: begin
                imem_req = reset_n;
                if (imem_ack) begin
                    ir_nx     = imem_data;
                    to_cnt_nx = '0;
                    state_nx  = EXEC;
                end else if (IMEM_TIMEOUT != 0 && to_cnt == TO_LAST) begin
                    state_nx = HALT;
                end else begin
                    to_cnt_nx = to_cnt + 32'd1;
                end
            end
            EXEC: begin
                if (ctrl.mem_read || ctrl.mem_write) begin
                    state_nx = MEM;
                end else if (ctrl.reg_write) begin
                    state_nx = WB;
                end else if (ctrl.is_beq) begin
                    state_nx = FETCH;
                    pc_nx    = Zero ? br_target : pc_plus4;
                end else if (ctrl.is_j) begin
                    state_nx = FETCH;
                    pc_nx    = j_target;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_nx = HALT;
`else
                    state_nx = FETCH;
                    pc_nx    = pc_plus4;
`endif
                end
            end
            MEM: begin
                MemRead  = ctrl.mem_read;
                MemWrite = ctrl.mem_write;
                if (mem_ack) begin
                    if (ctrl.mem_read) begin
                        state_nx = WB;
                    end else begin
                        state_nx = FETCH;
                        pc_nx    = pc_plus4;
                    end
                end
            end
            WB: begin
                RegWrite = ctrl.reg_write;
                state_nx = FETCH;
                pc_nx    = pc_plus4;
            end
            HALT: begin
                halt = 1'b1;
            end
            default: state_nx = FETCH;
        endcase
    end

endmodule

// File: tb/tb_cpu_iu.sv
// Scoreboard bench for cpu_iu: the stimulus pushes expected fetch/write events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_cpu_iu;

    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_REGWR = 2'd1;
    localparam logic [1:0] K_MEMRD = 2'd2;
    localparam logic [1:0] K_MEMWR = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [7:0]  ctl;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [25:0] Instruction;
    logic        RegDst, ALUSrc, RegWrite, MemtoReg;
    logic [1:0]  ALUOp;
    logic        MemRead, MemWrite;
    logic        mem_ack;
    logic        Zero;
    logic [31:0] SEImm;
    logic [31:0] pc;
    logic        halt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned memrd_cycles = 0;
    ev_t         exp_q[$];
    ev_t         ob, ex;
    logic        have;
    logic [7:0]  ctlv;

    cpu_iu #(.RESET_PC(32'h0000_0100), .IMEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .Instruction (Instruction),
        .RegDst      (RegDst),
        .ALUSrc      (ALUSrc),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .ALUOp       (ALUOp),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .mem_ack     (mem_ack),
        .Zero        (Zero),
        .SEImm       (SEImm),
        .pc          (pc),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    assign ctlv = {1'b0, MemRead, MemWrite, RegDst, ALUSrc, MemtoReg, ALUOp};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic ev_t mk(input logic [1:0] k, input logic [31:0] p, input logic [7:0] c);
        ev_t e;
        e.kind = k;
        e.pc   = p;
        e.ctl  = c;
        return e;
    endfunction

    // Monitor: one observable event per cycle at most, compared in issue order
    always @(negedge clk) begin
        if (reset_n) begin
            have = 1'b1;
            if (imem_req && imem_ack)      ob = mk(K_FETCH, imem_addr, ctlv);
            else if (RegWrite)             ob = mk(K_REGWR, pc, ctlv);
            else if (MemRead && mem_ack)   ob = mk(K_MEMRD, pc, ctlv);
            else if (MemWrite && mem_ack)  ob = mk(K_MEMWR, pc, ctlv);
            else                           have = 1'b0;
            if (have) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: got %h, expected none", ob);
                end else begin
                    ex = exp_q.pop_front();
                    chk("event", 64'(ob), 64'(ex));
                end
            end
            if (MemRead) memrd_cycles++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] instr, input int unsigned dly);
        exp_q.push_back(mk(K_FETCH, addr, 8'h00));
        repeat (dly) cyc();
        imem_ack  = 1'b1;
        imem_data = instr;
        cyc();
        imem_ack  = 1'b0;
        imem_data = '0;
    endtask

    task automatic mem(input int unsigned dly);
        repeat (dly) cyc();
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        imem_ack  = 1'b0;
        imem_data = '0;
        mem_ack   = 1'b0;
        Zero      = 1'b0;
        SEImm     = '0;

        repeat (2) cyc();
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_pc", 64'(pc), 64'h100);
        chk("rst_ctl", 64'({halt, RegWrite, MemWrite, MemRead, RegDst, ALUSrc, MemtoReg, ALUOp}), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("first_fetch_req", 64'(imem_req), 64'd1);
        chk("first_fetch_addr", 64'(imem_addr), 64'h100);

        // add $3,$1,$2 at 0x100: RegDst=1, ALUOp=10, RegWrite in cycle 3
        fetch(32'h100, 32'h0022_1820, 0);
        exp_q.push_back(mk(K_REGWR, 32'h100, 8'h12));
        cyc(); cyc();
        chk("add_pc", 64'(pc), 64'h104);

        // beq taken, SEImm=-2: 0x108-8 = 0x100
        Zero = 1'b1; SEImm = 32'hFFFF_FFFE;
        fetch(32'h104, 32'h1000_FFFE, 1);
        cyc();
        chk("beq_taken_pc", 64'(pc), 64'h100);

        fetch(32'h100, 32'h0022_1820, 0);
        exp_q.push_back(mk(K_REGWR, 32'h100, 8'h12));
        cyc(); cyc();

        // beq not taken -> 0x108
        Zero = 1'b0;
        fetch(32'h104, 32'h1000_FFFE, 0);
        cyc();
        chk("beq_nt_pc", 64'(pc), 64'h108);

        // addi with fetch ack on the last cycle before timeout
        fetch(32'h108, 32'h2001_0005, 3);
        exp_q.push_back(mk(K_REGWR, 32'h108, 8'h08));
        cyc(); cyc();
        chk("addi_pc", 64'(pc), 64'h10C);

        // lw with mem_ack in the third MEM cycle
        memrd_cycles = 0;
        fetch(32'h10C, 32'h8C22_0004, 0);
        exp_q.push_back(mk(K_MEMRD, 32'h10C, 8'h4C));
        exp_q.push_back(mk(K_REGWR, 32'h10C, 8'h0C));
        cyc(); mem(2); cyc();
        chk("lw_memread_cycles", 64'(memrd_cycles), 64'd3);
        chk("lw_pc", 64'(pc), 64'h110);

        fetch(32'h110, 32'hAC22_0008, 0);
        exp_q.push_back(mk(K_MEMWR, 32'h110, 8'h28));
        cyc(); mem(1);
        chk("sw_pc", 64'(pc), 64'h114);

        // long forward branch to 0x1000_0000
        Zero = 1'b1; SEImm = 32'h03FF_FFBA;
        fetch(32'h114, 32'h1000_0000, 0);
        cyc();
        chk("beq_far_pc", 64'(pc), 64'h1000_0000);

        fetch(32'h1000_0000, 32'h0800_0040, 0);
        cyc();
        chk("j_pc", 64'(pc), 64'h1000_0100);

        // backward-wrapping branch to 0xFFFF_FFFC
        SEImm = 32'hFBFF_FFBE;
        fetch(32'h1000_0100, 32'h1000_0000, 0);
        cyc();
        chk("beq_wrap_pc", 64'(pc), 64'hFFFF_FFFC);
        Zero = 1'b0;

        fetch(32'hFFFF_FFFC, 32'h2001_0001, 0);
        exp_q.push_back(mk(K_REGWR, 32'hFFFF_FFFC, 8'h08));
        cyc(); cyc();
        chk("pc_wrap", 64'(pc), 64'h0);

        // reset during sw MEM: MemWrite drops at once, no late write
        fetch(32'h0, 32'hAC22_0008, 0);
        cyc(); cyc();
        chk("sw_mem_active", 64'(MemWrite), 64'd1);
        mem_ack = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("sw_rst_memwrite", 64'(MemWrite), 64'd0);
        chk("sw_rst_pc", 64'(pc), 64'h100);
        cyc(); cyc();
        mem_ack = 1'b0;
        reset_n = 1'b1;

        // reset during WB: RegWrite drops at once
        fetch(32'h100, 32'h0022_1820, 0);
        cyc();
        chk("wb_regwrite_active", 64'(RegWrite), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("wb_rst_regwrite", 64'(RegWrite), 64'd0);
        chk("wb_rst_pc", 64'(pc), 64'h100);
        cyc(); cyc();
        reset_n = 1'b1;

        // undecoded opcode 0x3F
        fetch(32'h100, 32'hFC00_0000, 0);
        cyc();
`ifdef ILLEGAL_TRAP_EN
        chk("illegal_halt", 64'(halt), 64'd1);
        chk("illegal_req", 64'(imem_req), 64'd0);
        chk("illegal_pc", 64'(pc), 64'h100);
`else
        chk("illegal_halt", 64'(halt), 64'd0);
        chk("illegal_pc", 64'(pc), 64'h104);
`endif
        chk("illegal_ctl", 64'(ctlv), 64'd0);

        // fetch timeout: no ack for 4 cycles
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        repeat (3) cyc();
        chk("timeout_not_yet", 64'(halt), 64'd0);
        cyc();
        chk("timeout_halt", 64'(halt), 64'd1);
        chk("timeout_req", 64'(imem_req), 64'd0);
        imem_ack = 1'b1;
        repeat (3) cyc();
        imem_ack = 1'b0;
        chk("halt_sticky", 64'(halt), 64'd1);
        chk("halt_pc", 64'(pc), 64'h100);

        cyc();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
